instr_encoder_loader: RTL and testbench

- Streaming LEGv8 instruction encoder and instruction-memory loader; the inverse of the opcode/control decode path.
- Accepts one symbolic instruction per handshake (mnemonic + register/immediate fields), packs it into the 32-bit R/I/D/CB/B format, and writes it to consecutive instruction-memory words.
- Sits between a testbench/host program source and the imem write port.
- Used to build programs for the nonpipelined core without external hex files.

---
 rtl/instr_encoder_loader_pkg.sv | 65 ++++++
 rtl/instr_encoder_loader_pack.sv | 64 ++++++
 rtl/instr_encoder_loader.sv | 148 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared LEGv8 encoder definitions: mnemonic codes, instruction formats,
// standard opcodes and loader FSM states.
package instr_encoder_loader_pkg;

  typedef enum logic [4:0] {
    MN_ADD    = 5'd0,
    MN_SUB    = 5'd1,
    MN_AND    = 5'd2,
    MN_ORR    = 5'd3,
    MN_ADDI   = 5'd4,
    MN_SUBI   = 5'd5,
    MN_ANDI   = 5'd6,
    MN_ORRI   = 5'd7,
    MN_EORI   = 5'd8,
    MN_LDUR   = 5'd9,
    MN_LDURB  = 5'd10,
    MN_LDURH  = 5'd11,
    MN_LDURSW = 5'd12,
    MN_STUR   = 5'd13,
    MN_STURB  = 5'd14,
    MN_STURH  = 5'd15,
    MN_STURW  = 5'd16,
    MN_CBZ    = 5'd17,
    MN_CBNZ   = 5'd18,
    MN_B      = 5'd19
  } mnem_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_D,
    FMT_CB,
    FMT_B
  } fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI   = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI   = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI   = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI   = 10'b1011001000;
  localparam logic [9:0]  OP_EORI   = 10'b1101001000;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_LDURB  = 11'b00111000010;
  localparam logic [10:0] OP_LDURH  = 11'b01111000010;
  localparam logic [10:0] OP_LDURSW = 11'b10111000100;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_STURB  = 11'b00111000000;
  localparam logic [10:0] OP_STURH  = 11'b01111000000;
  localparam logic [10:0] OP_STURW  = 11'b10111000000;
  localparam logic [7:0]  OP_CBZ    = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ   = 8'b10110101;
  localparam logic [5:0]  OP_B      = 6'b000101;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational LEGv8 packer: mnemonic plus operand fields to a 32-bit
// instruction word, with a flag for recognised mnemonics.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rn_i,
  input  logic [4:0]  rm_i,
  input  logic [5:0]  shamt_i,
  input  logic [25:0] imm_i,
  output logic [31:0] word_o,
  output logic        valid_o
);

  fmt_e        fmt;
  logic [10:0] op;

  always_comb begin
    fmt     = FMT_B;
    op      = '0;
    valid_o = 1'b1;
    case (mnem_i)
      MN_ADD:    begin fmt = FMT_R;  op = OP_ADD;         end
      MN_SUB:    begin fmt = FMT_R;  op = OP_SUB;         end
      MN_AND:    begin fmt = FMT_R;  op = OP_AND;         end
      MN_ORR:    begin fmt = FMT_R;  op = OP_ORR;         end
      MN_ADDI:   begin fmt = FMT_I;  op = 11'(OP_ADDI);   end
      MN_SUBI:   begin fmt = FMT_I;  op = 11'(OP_SUBI);   end
      MN_ANDI:   begin fmt = FMT_I;  op = 11'(OP_ANDI);   end
      MN_ORRI:   begin fmt = FMT_I;  op = 11'(OP_ORRI);   end
      MN_EORI:   begin fmt = FMT_I;  op = 11'(OP_EORI);   end
      MN_LDUR:   begin fmt = FMT_D;  op = OP_LDUR;        end
      MN_LDURB:  begin fmt = FMT_D;  op = OP_LDURB;       end
      MN_LDURH:  begin fmt = FMT_D;  op = OP_LDURH;       end
      MN_LDURSW: begin fmt = FMT_D;  op = OP_LDURSW;      end
      MN_STUR:   begin fmt = FMT_D;  op = OP_STUR;        end
      MN_STURB:  begin fmt = FMT_D;  op = OP_STURB;       end
      MN_STURH:  begin fmt = FMT_D;  op = OP_STURH;       end
      MN_STURW:  begin fmt = FMT_D;  op = OP_STURW;       end
      MN_CBZ:    begin fmt = FMT_CB; op = 11'(OP_CBZ);    end
      MN_CBNZ:   begin fmt = FMT_CB; op = 11'(OP_CBNZ);   end
      MN_B:      begin fmt = FMT_B;  op = 11'(OP_B);      end
      default:   valid_o = 1'b0;
    endcase
  end

  // Opcodes narrower than 11 bits sit zero-extended in op; each format
  // slices only its own opcode width.
  always_comb begin
    word_o = '0;
    if (valid_o) begin
      case (fmt)
        FMT_R:   word_o = {op, rm_i, shamt_i, rn_i, rd_i};
        FMT_I:   word_o = {op[9:0], imm_i[11:0], rn_i, rd_i};
        FMT_D:   word_o = {op, imm_i[8:0], 2'b00, rn_i, rd_i};
        FMT_CB:  word_o = {op[7:0], imm_i[18:0], rd_i};
        FMT_B:   word_o = {op[5:0], imm_i};
        default: word_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streaming LEGv8 encoder and instruction-memory loader.
// Define INSTR_LOADER_CHECKSUM_EN to add a running XOR checksum output.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [5:0]        in_shamt,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  state_e            state_q;
  logic              in_ready_q, imem_we_q, busy_q, done_q, error_q, drain_err_q;
  logic [ADDR_W-1:0] imem_addr_q, next_addr_q, next_addr_d;
  logic [31:0]       imem_wdata_q, enc_word_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              enc_valid_d, accept_d;

  instr_pack u_pack (
    .mnem_i  (in_mnem),
    .rd_i    (in_rd),
    .rn_i    (in_rn),
    .rm_i    (in_rm),
    .shamt_i (in_shamt),
    .imm_i   (in_imm),
    .word_o  (enc_word_d),
    .valid_o (enc_valid_d)
  );

  assign accept_d    = in_valid && in_ready_q;
  assign count_d     = count_q + 1'b1;
  assign next_addr_d = next_addr_q + 1'b1;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
  assign checksum = csum_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      drain_err_q  <= 1'b0;
      imem_addr_q  <= BASE_C;
      next_addr_q  <= BASE_C;
      imem_wdata_q <= '0;
      count_q      <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (imem_we_q) csum_q <= csum_q ^ imem_wdata_q;
`endif
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_q     <= ST_LOAD;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
            next_addr_q <= BASE_C;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (accept_d) begin
            if (!enc_valid_d) begin
              state_q    <= ST_ERROR;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= next_addr_q;
              imem_wdata_q <= enc_word_d;
              next_addr_q  <= next_addr_d;
              count_q      <= count_d;
              // A full session without in_last still drains its final
              // write before reporting the overflow.
              if (in_last || count_d == DEPTH_C) begin
                state_q     <= ST_DRAIN;
                in_ready_q  <= 1'b0;
                drain_err_q <= !in_last;
              end
            end
          end
        end
        ST_DRAIN: begin
          busy_q <= 1'b0;
          if (drain_err_q) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: reference encoder and
// session model compared against the DUT every cycle, plus literal pins.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  localparam int AW   = 3;
  localparam int DEP  = 5;
  localparam int BASE = 6;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0;
  logic [4:0]    in_mnem = '0, in_rd = '0, in_rn = '0, in_rm = '0;
  logic [5:0]    in_shamt = '0;
  logic [25:0]   in_imm = '0;
  logic          in_ready, imem_we, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DEP), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .error(error), .count(count)
`ifdef INSTR_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // Session model: 0 idle, 1 load, 2 draining to done, 3 draining to error,
  // 4 done, 5 error.
  int          m_mode = 0, m_cnt = 0, m_nxt = BASE, e_addr = BASE;
  logic        e_we = 1'b0;
  logic [31:0] e_data = '0, e_ck = '0;
  logic [32:0] m_enc;
  bit          m_acc;
  logic [35:0] wlog[$];
  int          wcyc[$];

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_enc(input logic [4:0] mn, input logic [4:0] rd,
                                          input logic [4:0] rn, input logic [4:0] rm,
                                          input logic [5:0] sh, input logic [25:0] imm);
    logic [31:0] op, w, im;
    int fmt;
    bit ok;
    ok = 1; op = 0; fmt = 0; w = 0;
    im = 32'(imm);
    case (mn)
      MN_ADD:    begin op = 32'h458; fmt = 0; end
      MN_SUB:    begin op = 32'h658; fmt = 0; end
      MN_AND:    begin op = 32'h450; fmt = 0; end
      MN_ORR:    begin op = 32'h550; fmt = 0; end
      MN_ADDI:   begin op = 32'h244; fmt = 1; end
      MN_SUBI:   begin op = 32'h344; fmt = 1; end
      MN_ANDI:   begin op = 32'h248; fmt = 1; end
      MN_ORRI:   begin op = 32'h2C8; fmt = 1; end
      MN_EORI:   begin op = 32'h348; fmt = 1; end
      MN_LDUR:   begin op = 32'h7C2; fmt = 2; end
      MN_LDURB:  begin op = 32'h1C2; fmt = 2; end
      MN_LDURH:  begin op = 32'h3C2; fmt = 2; end
      MN_LDURSW: begin op = 32'h5C4; fmt = 2; end
      MN_STUR:   begin op = 32'h7C0; fmt = 2; end
      MN_STURB:  begin op = 32'h1C0; fmt = 2; end
      MN_STURH:  begin op = 32'h3C0; fmt = 2; end
      MN_STURW:  begin op = 32'h5C0; fmt = 2; end
      MN_CBZ:    begin op = 32'hB4;  fmt = 3; end
      MN_CBNZ:   begin op = 32'hB5;  fmt = 3; end
      MN_B:      begin op = 32'h05;  fmt = 4; end
      default:   ok = 0;
    endcase
    if (!ok) return '0;
    case (fmt)
      0: w = (op << 21) | (32'(rm) << 16) | (32'(sh) << 10) | (32'(rn) << 5) | 32'(rd);
      1: w = (op << 22) | ((im % 4096) << 10) | (32'(rn) << 5) | 32'(rd);
      2: w = (op << 21) | ((im % 512) << 12) | (32'(rn) << 5) | 32'(rd);
      3: w = (op << 24) | ((im % (1 << 19)) << 5) | 32'(rd);
      default: w = (op << 26) | (im % (1 << 26));
    endcase
    return {1'b1, w};
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_nxt = BASE;
      e_we = 1'b0; e_addr = BASE; e_data = '0; e_ck = '0;
    end else begin
      cyc++;
      m_acc = in_valid && (m_mode == 1) && (m_cnt < DEP);
      if (e_we) e_ck = e_ck ^ e_data;
      e_we = 1'b0;
      if (start && (m_mode == 0 || m_mode >= 4)) begin
        m_mode = 1; m_cnt = 0; m_nxt = BASE; e_ck = '0;
      end else if (m_mode == 2) begin
        m_mode = 4;
      end else if (m_mode == 3) begin
        m_mode = 5;
      end else if (m_acc) begin
        m_enc = ref_enc(in_mnem, in_rd, in_rn, in_rm, in_shamt, in_imm);
        if (!m_enc[32]) begin
          m_mode = 5;
        end else begin
          e_we = 1'b1; e_addr = m_nxt; e_data = m_enc[31:0];
          m_nxt = (m_nxt + 1) % (1 << AW);
          m_cnt++;
          if (in_last) m_mode = 2;
          else if (m_cnt == DEP) m_mode = 3;
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("in_ready", 36'(in_ready), 36'(m_mode == 1 && m_cnt < DEP));
      chk("imem_we", 36'(imem_we), 36'(e_we));
      chk("imem_addr", 36'(imem_addr), 36'(e_addr));
      chk("imem_wdata", 36'(imem_wdata), 36'(e_data));
      chk("count", 36'(count), 36'(m_cnt));
      chk("busy", 36'(busy), 36'(m_mode >= 1 && m_mode <= 3));
      chk("done", 36'(done), 36'(m_mode == 4));
      chk("error", 36'(error), 36'(m_mode == 5));
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk("checksum", 36'(checksum), 36'(e_ck));
`endif
    end
  end

  initial forever begin
    @(negedge clk);
    if (imem_we === 1'b1) begin
      wlog.push_back({4'(imem_addr), imem_wdata});
      wcyc.push_back(cyc);
    end
  end

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input logic [4:0] mn, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [5:0] sh, input logic [25:0] imm,
                      input logic last);
    int n;
    @(negedge clk); #1;
    in_valid = 1'b1; in_mnem = mn; in_rd = rd; in_rn = rn; in_rm = rm;
    in_shamt = sh; in_imm = imm; in_last = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after 20 cycles, required 1", in_ready);
    end else begin
      @(posedge clk);
    end
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  logic [35:0] exp1 [5] = '{{4'd6, 32'h8B020023}, {4'd7, 32'h91001401}, {4'd0, 32'hF8408022},
                            {4'd1, 32'hB4FFFFC3}, {4'd2, 32'h17FFFFFF}};

  initial begin
    chk("ref_add",   36'(ref_enc(MN_ADD, 3, 1, 2, 0, 0)),            {3'b0, 1'b1, 32'h8B020023});
    chk("ref_addi",  36'(ref_enc(MN_ADDI, 1, 0, 0, 0, 5)),           {3'b0, 1'b1, 32'h91001401});
    chk("ref_ldur",  36'(ref_enc(MN_LDUR, 2, 1, 0, 0, 8)),           {3'b0, 1'b1, 32'hF8408022});
    chk("ref_cbz",   36'(ref_enc(MN_CBZ, 3, 0, 0, 0, 26'h3FFFFFE)),  {3'b0, 1'b1, 32'hB4FFFFC3});
    chk("ref_b",     36'(ref_enc(MN_B, 0, 0, 0, 0, 26'h3FFFFFF)),    {3'b0, 1'b1, 32'h17FFFFFF});
    chk("ref_stur",  36'(ref_enc(MN_STUR, 5, 6, 0, 0, 26'h3FFFFFF)), {3'b0, 1'b1, 32'hF81FF0C5});
    chk("ref_andi",  36'(ref_enc(MN_ANDI, 9, 7, 0, 0, 26'h3FFF)),    {3'b0, 1'b1, 32'h923FFCE9});
    chk("ref_bad",   36'(ref_enc(5'h1F, 1, 1, 1, 1, 1)),             36'h0);

    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 36'(count), 36'h0);
    chk("rst_addr", 36'(imem_addr), 36'(BASE));
    chk("rst_ready", 36'(in_ready), 36'h0);

    // Directed session ending with in_last exactly at DEPTH, wrapping addr.
    wlog.delete(); wcyc.delete();
    pulse_start();
    send(MN_ADD, 3, 1, 2, 0, 0, 0);
    send(MN_ADDI, 1, 0, 0, 0, 5, 0);
    send(MN_LDUR, 2, 1, 0, 0, 8, 0);
    send(MN_CBZ, 3, 0, 0, 0, 26'h3FFFFFE, 0);
    send(MN_B, 0, 0, 0, 0, 26'h3FFFFFF, 1);
    repeat (3) @(negedge clk);
    chk("s1_nwrites", 36'(wlog.size()), 36'd5);
    for (int i = 0; i < wlog.size() && i < 5; i++)
      chk($sformatf("s1_write%0d", i), wlog[i], exp1[i]);
    if (wcyc.size() >= 3) chk("s1_b2b", 36'(wcyc[2] - wcyc[1]), 36'd1);
    chk("s1_done", 36'(done), 36'h1);
    chk("s1_busy", 36'(busy), 36'h0);
    chk("s1_ready", 36'(in_ready), 36'h0);
    chk("s1_count", 36'(count), 36'd5);

    // Overflow: DEPTH accepts without in_last, then a refused sixth offer.
    wlog.delete();
    pulse_start();
    for (int i = 0; i < DEP; i++)
      send(5'($urandom_range(0, 19)), 5'($urandom), 5'($urandom), 5'($urandom),
           6'($urandom), 26'($urandom), 1'b0);
    @(negedge clk); #1 in_valid = 1'b1; in_mnem = MN_ADD;
    repeat (4) @(negedge clk);
    #1 in_valid = 1'b0;
    chk("ovf_nwrites", 36'(wlog.size()), 36'd5);
    chk("ovf_error", 36'(error), 36'h1);
    chk("ovf_ready", 36'(in_ready), 36'h0);
    chk("ovf_count", 36'(count), 36'd5);

    // Unknown mnemonic mid-stream, then a fresh start.
    wlog.delete();
    pulse_start();
    send(MN_SUB, 4, 5, 6, 7, 0, 0);
    send(MN_ORRI, 8, 9, 0, 0, 26'h123, 0);
    send(5'h1F, 1, 2, 3, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("bad_nwrites", 36'(wlog.size()), 36'd2);
    chk("bad_error", 36'(error), 36'h1);
    chk("bad_count", 36'(count), 36'd2);
    pulse_start();
    @(negedge clk);
    chk("restart_error", 36'(error), 36'h0);
    chk("restart_count", 36'(count), 36'h0);
    chk("restart_ready", 36'(in_ready), 36'h1);

    for (int s = 0; s < 40; s++) begin
      int len;
      pulse_start();
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        logic [4:0] mn;
        if (!(m_mode == 1 && m_cnt < DEP)) break;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if ($urandom_range(0, 9) == 0) pulse_start();
        mn = ($urandom_range(0, 14) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
        send(mn, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 26'($urandom),
             (k == len - 1) && ($urandom_range(0, 3) != 0));
      end
      repeat (2) @(negedge clk);
    end

    // Reset landing on a write cycle.
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    pulse_start();
    wlog.delete();
    send(MN_SUB, 4, 5, 6, 0, 0, 0);
    chk("rst_pre_we", 36'(imem_we), 36'h1);
    #2 reset = 1'b1;
    in_valid = 1'b1; in_mnem = MN_ADD;
    #1;
    chk("arst_we", 36'(imem_we), 36'h0);
    chk("arst_busy", 36'(busy), 36'h0);
    chk("arst_count", 36'(count), 36'h0);
    chk("arst_addr", 36'(imem_addr), 36'(BASE));
    chk("arst_wdata", 36'(imem_wdata), 36'h0);
    chk("arst_ready", 36'(in_ready), 36'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    #1 in_valid = 1'b0;
    chk("arst_nwrites", 36'(wlog.size()), 36'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
